ex_fwd_ctrl: RTL and testbench

- Forwarding/hazard control unit directly upstream of the EX-stage operand select mux.
- Tracks destination-register tags of in-flight instructions in MEM, WB and WB-late.
- Produces the per-operand forward-source select (fw_cntrl) consumed by EX, and detects load-use hazards.
- On a load-use hazard it asserts a one-cycle stall and inserts a bubble into MEM.

---
 rtl/ex_fwd_ctrl_if.sv | 54 +++++
 rtl/ex_fwd_ctrl.sv | 158 +++++++++++++++
 tb/tb_ex_fwd_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ex_fwd_ctrl_if.sv
// ex_fwd_ctrl_if: EX-stage request / forwarding-response bundle for ex_fwd_ctrl.
//
// Naming is from the forwarding unit's point of view: *_i signals are driven by the pipeline
// (master) and *_o signals are driven by the forwarding unit (slave).
//   ex_valid_i, ex_rs1_i, ex_rs2_i, ex_rs1_used_i, ex_rs2_used_i : EX operand request
//   ex_rd_i, ex_wr_en_i, ex_is_load_i                            : EX destination info
//   flush_i                                                      : kill the EX instruction
//   pipe_stall_i                                                 : MEM/WB freeze
//   fw_rs1_o, fw_rs2_o : forward select (0 none, 1 MEM, 2 WB, 3 WB-late)
//   stall_o            : load-use stall request
//   mem_tag_vld_o      : debug view of the MEM tag slot
// Optional build macro FWD_PERF_CNT_EN adds perf_stall_cnt_o / perf_fwd_cnt_o.
interface ex_fwd_ctrl_if #(
  parameter int unsigned NREGS = 32
);
  localparam int unsigned TagW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic            ex_valid_i;
  logic [TagW-1:0] ex_rs1_i;
  logic [TagW-1:0] ex_rs2_i;
  logic            ex_rs1_used_i;
  logic            ex_rs2_used_i;
  logic [TagW-1:0] ex_rd_i;
  logic            ex_wr_en_i;
  logic            ex_is_load_i;
  logic            flush_i;
  logic            pipe_stall_i;
  logic [1:0]      fw_rs1_o;
  logic [1:0]      fw_rs2_o;
  logic            stall_o;
  logic            mem_tag_vld_o;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]     perf_stall_cnt_o;
  logic [31:0]     perf_fwd_cnt_o;
`endif

  modport master (
    output ex_valid_i, ex_rs1_i, ex_rs2_i, ex_rs1_used_i, ex_rs2_used_i,
    output ex_rd_i, ex_wr_en_i, ex_is_load_i, flush_i, pipe_stall_i,
`ifdef FWD_PERF_CNT_EN
    input  perf_stall_cnt_o, perf_fwd_cnt_o,
`endif
    input  fw_rs1_o, fw_rs2_o, stall_o, mem_tag_vld_o
  );

  modport slave (
    input  ex_valid_i, ex_rs1_i, ex_rs2_i, ex_rs1_used_i, ex_rs2_used_i,
    input  ex_rd_i, ex_wr_en_i, ex_is_load_i, flush_i, pipe_stall_i,
`ifdef FWD_PERF_CNT_EN
    output perf_stall_cnt_o, perf_fwd_cnt_o,
`endif
    output fw_rs1_o, fw_rs2_o, stall_o, mem_tag_vld_o
  );
endinterface

// File: rtl/ex_fwd_ctrl.sv
// ex_fwd_ctrl: EX-stage forwarding and load-use hazard control.
//
// Tracks destination tags of the instructions in MEM, WB and WB-late and, for each EX source
// operand, selects the youngest in-flight producer. A load that is still too young to forward
// raises a one-cycle stall and a bubble is placed into MEM.
//
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   bus     : ex_fwd_ctrl_if.slave (EX request in, forward selects / stall out)
// Parameters:
//   NREGS           : architectural register count (tag width clog2(NREGS))
//   LOAD_USE_CYCLES : cycles before a load result can be forwarded, legal 1..3
// Optional build macro FWD_PERF_CNT_EN adds stall / forward cycle counters.
module ex_fwd_ctrl #(
  parameter int unsigned NREGS           = 32,
  parameter int unsigned LOAD_USE_CYCLES = 1
) (
  input logic          clk_i,
  input logic          rst_ni,
  ex_fwd_ctrl_if.slave bus
);

  localparam int unsigned TagW   = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [1:0]  AgeMax = 2'(LOAD_USE_CYCLES);

  typedef enum logic [1:0] {
    FwNone   = 2'd0,
    FwMem    = 2'd1,
    FwWb     = 2'd2,
    FwWbLate = 2'd3
  } fw_sel_e;

  typedef struct packed {
    logic            vld;
    logic [TagW-1:0] rd;
    logic            is_load;
    logic [1:0]      age;
  } slot_t;

  typedef struct packed {
    fw_sel_e sel;
    logic    haz;
  } fw_res_t;

  slot_t   mem_q, mem_d;
  slot_t   wb_q, wb_d;
  slot_t   wbl_q, wbl_d;
  fw_res_t rs1_res, rs2_res;
  logic    stall;

  function automatic logic [1:0] age_inc(input logic [1:0] age);
    return (age >= AgeMax) ? AgeMax : age + 2'd1;
  endfunction

  // Only the youngest matching producer is considered: an older young load shadowed by a newer
  // writer of the same register does not hold the value EX needs, so it is not a hazard.
  function automatic fw_res_t resolve(input logic req, input logic [TagW-1:0] rs,
                                      input slot_t m, input slot_t w, input slot_t l);
    fw_res_t res;
    slot_t   hit;
    res.sel = FwNone;
    res.haz = 1'b0;
    hit     = '0;
    if (req && (rs != '0)) begin
      if (m.vld && (m.rd == rs)) begin
        res.sel = FwMem;
        hit     = m;
      end else if (w.vld && (w.rd == rs)) begin
        res.sel = FwWb;
        hit     = w;
      end else if (l.vld && (l.rd == rs)) begin
        res.sel = FwWbLate;
        hit     = l;
      end
      if (hit.is_load && (hit.age < AgeMax)) begin
        res.sel = FwNone;
        res.haz = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    rs1_res = resolve(bus.ex_valid_i & bus.ex_rs1_used_i, bus.ex_rs1_i, mem_q, wb_q, wbl_q);
    rs2_res = resolve(bus.ex_valid_i & bus.ex_rs2_used_i, bus.ex_rs2_i, mem_q, wb_q, wbl_q);
    // Flush wins: a killed instruction must not freeze the front end.
    stall   = (rs1_res.haz | rs2_res.haz) & bus.ex_valid_i & ~bus.flush_i;
  end

  // Slot advance; while stalling the MEM slot takes a bubble, and a freeze holds everything,
  // including a pending bubble, until pipe_stall_i drops.
  always_comb begin
    mem_d = mem_q;
    wb_d  = wb_q;
    wbl_d = wbl_q;
    if (!bus.pipe_stall_i) begin
      wbl_d         = wb_q;
      wbl_d.age     = age_inc(wb_q.age);
      wb_d          = mem_q;
      wb_d.age      = age_inc(mem_q.age);
      mem_d.vld     = bus.ex_valid_i & bus.ex_wr_en_i & ~bus.flush_i & ~stall &
                      (bus.ex_rd_i != '0);
      mem_d.rd      = bus.ex_rd_i;
      mem_d.is_load = bus.ex_is_load_i;
      mem_d.age     = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wb_q  <= '0;
      wbl_q <= '0;
    end else begin
      mem_q <= mem_d;
      wb_q  <= wb_d;
      wbl_q <= wbl_d;
    end
  end

  assign bus.fw_rs1_o      = rs1_res.sel;
  assign bus.fw_rs2_o      = rs2_res.sel;
  assign bus.stall_o       = stall;
  assign bus.mem_tag_vld_o = mem_q.vld;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_fwd_cnt_q, perf_fwd_cnt_d;

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q;
    perf_fwd_cnt_d   = perf_fwd_cnt_q;
    if (!bus.pipe_stall_i) begin
      if (stall) begin
        perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
      end
      if (bus.ex_valid_i && ((rs1_res.sel != FwNone) || (rs2_res.sel != FwNone))) begin
        perf_fwd_cnt_d = perf_fwd_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_cnt_q <= '0;
      perf_fwd_cnt_q   <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_fwd_cnt_q   <= perf_fwd_cnt_d;
    end
  end

  assign bus.perf_stall_cnt_o = perf_stall_cnt_q;
  assign bus.perf_fwd_cnt_o   = perf_fwd_cnt_q;
`endif

endmodule

// File: tb/tb_ex_fwd_ctrl.sv
// Self-checking bench for ex_fwd_ctrl: directed scenarios followed by random traffic, all
// checked against a history-based reference model (position in history = cycles since MEM).
module tb_ex_fwd_ctrl;
  localparam int LUC = 1;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ex_fwd_ctrl_if #(.NREGS(32)) bus ();

  ex_fwd_ctrl #(.NREGS(32), .LOAD_USE_CYCLES(LUC)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  // hist[0] = newest producer (MEM), hist[1] = WB, hist[2] = WB-late.
  typedef struct {bit vld; int rd; bit ld;} ent_t;
  ent_t hist[3];
`ifdef FWD_PERF_CNT_EN
  longint m_stall_cnt = 0;
  longint m_fwd_cnt = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) hist[i] = '{vld: 1'b0, rd: 0, ld: 1'b0};
  endtask

  // Youngest matching producer wins; a load younger than LUC cycles cannot forward yet.
  task automatic model_fw(input bit req, input int rs, output int fw, output bit haz);
    fw = 0;
    haz = 1'b0;
    if (req && rs != 0) begin
      for (int i = 0; i < 3; i++) begin
        if (hist[i].vld && hist[i].rd == rs) begin
          if (hist[i].ld && i < LUC) haz = 1'b1;
          else fw = i + 1;
          break;
        end
      end
    end
  endtask

  task automatic drv(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit wr, input bit ld, input bit fl, input bit ps);
    bus.ex_valid_i    = v;
    bus.ex_rs1_i      = 5'(rs1);
    bus.ex_rs1_used_i = u1;
    bus.ex_rs2_i      = 5'(rs2);
    bus.ex_rs2_used_i = u2;
    bus.ex_rd_i       = 5'(rd);
    bus.ex_wr_en_i    = wr;
    bus.ex_is_load_i  = ld;
    bus.flush_i       = fl;
    bus.pipe_stall_i  = ps;
  endtask

  // One clock: compare at negedge against the model (and optional constants, -1 = skip),
  // then advance the model at posedge. Entered and left at posedge + 1.
  task automatic cyc(input string tag, input int e1, input int e2, input int es, input int em);
    int f1, f2;
    bit h1, h2, st;
    model_fw(bus.ex_valid_i && bus.ex_rs1_used_i, int'(bus.ex_rs1_i), f1, h1);
    model_fw(bus.ex_valid_i && bus.ex_rs2_used_i, int'(bus.ex_rs2_i), f2, h2);
    st = (h1 || h2) && bus.ex_valid_i && !bus.flush_i;
    @(negedge clk_i);
    chk({tag, ".fw1"}, 32'(bus.fw_rs1_o), 32'(f1));
    chk({tag, ".fw2"}, 32'(bus.fw_rs2_o), 32'(f2));
    chk({tag, ".stall"}, 32'(bus.stall_o), 32'(st));
    chk({tag, ".memv"}, 32'(bus.mem_tag_vld_o), 32'(hist[0].vld));
    if (e1 >= 0) chk({tag, ".fw1_exp"}, 32'(bus.fw_rs1_o), 32'(e1));
    if (e2 >= 0) chk({tag, ".fw2_exp"}, 32'(bus.fw_rs2_o), 32'(e2));
    if (es >= 0) chk({tag, ".stall_exp"}, 32'(bus.stall_o), 32'(es));
    if (em >= 0) chk({tag, ".memv_exp"}, 32'(bus.mem_tag_vld_o), 32'(em));
`ifdef FWD_PERF_CNT_EN
    chk({tag, ".pstall"}, bus.perf_stall_cnt_o, 32'(m_stall_cnt));
    chk({tag, ".pfwd"}, bus.perf_fwd_cnt_o, 32'(m_fwd_cnt));
`endif
    @(posedge clk_i);
    if (!bus.pipe_stall_i) begin
`ifdef FWD_PERF_CNT_EN
      if (st) m_stall_cnt++;
      if (bus.ex_valid_i && (f1 != 0 || f2 != 0)) m_fwd_cnt++;
`endif
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0].vld = !st && bus.ex_valid_i && bus.ex_wr_en_i && !bus.flush_i &&
                    bus.ex_rd_i != 5'd0;
      hist[0].rd  = int'(bus.ex_rd_i);
      hist[0].ld  = bus.ex_is_load_i;
    end
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    rst_ni = 1'b0;
    #1;
    chk({tag, ".fw1"}, 32'(bus.fw_rs1_o), 32'd0);
    chk({tag, ".fw2"}, 32'(bus.fw_rs2_o), 32'd0);
    chk({tag, ".stall"}, 32'(bus.stall_o), 32'd0);
    chk({tag, ".memv"}, 32'(bus.mem_tag_vld_o), 32'd0);
    model_clear();
`ifdef FWD_PERF_CNT_EN
    m_stall_cnt = 0;
    m_fwd_cnt = 0;
`endif
    #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    model_clear();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("in_reset.fw1", 32'(bus.fw_rs1_o), 32'd0);
    chk("in_reset.stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    cyc("reset_state", 0, 0, 0, 0);

    // ALU x5 walks MEM -> WB -> WBL -> gone
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); cyc("alu5_in", 0, 0, 0, 0);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); cyc("alu5_mem", 1, 0, 0, 1);
    drv(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); cyc("alu5_wb", 0, 2, 0, 0);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); cyc("alu5_wbl", 3, 0, 0, 0);
    cyc("alu5_gone", 0, 0, 0, 0);

    // load-use on x7: one stall cycle, bubble, then forward from WB
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 0); cyc("ld7_in", 0, 0, 0, 0);
    drv(1, 0, 0, 7, 1, 0, 0, 0, 0, 0); cyc("ld7_use", 0, 0, 1, 1);
    cyc("ld7_fwd", 0, 2, 0, 0);

    // x0 never tracked or forwarded
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); cyc("x0_alu", 0, 0, 0, 0);
    drv(1, 0, 1, 0, 0, 0, 1, 1, 0, 0); cyc("x0_ld", 0, 0, 0, 0);
    drv(1, 0, 1, 0, 1, 0, 0, 0, 0, 0); cyc("x0_ld_use", 0, 0, 0, 0);

    // x3 in both MEM and WB: MEM wins
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); cyc("x3_a", -1, -1, 0, -1);
    cyc("x3_b", -1, -1, 0, 1);
    drv(1, 3, 1, 3, 1, 0, 0, 0, 0, 0); cyc("x3_use", 1, 1, 0, 1);

    // flushed writer is not tracked; flush suppresses a load-use stall
    drv(1, 0, 0, 0, 0, 9, 1, 0, 1, 0); cyc("fl9", -1, -1, 0, -1);
    drv(1, 9, 1, 9, 1, 0, 0, 0, 0, 0); cyc("fl9_use", 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 8, 1, 1, 0, 0); cyc("ld8_in", -1, -1, 0, -1);
    drv(1, 8, 1, 0, 0, 0, 0, 0, 1, 0); cyc("ld8_flush", 0, 0, 0, 1);

    // hazard during freeze: stall held, bubble only once the freeze lifts
    drv(1, 0, 0, 0, 0, 6, 1, 1, 0, 0); cyc("ld6_in", -1, -1, 0, -1);
    drv(1, 6, 1, 0, 0, 0, 0, 0, 0, 1); cyc("ld6_frz0", 0, 0, 1, 1);
    cyc("ld6_frz1", 0, 0, 1, 1);
    drv(1, 6, 1, 0, 0, 0, 0, 0, 0, 0); cyc("ld6_rel", 0, 0, 1, 1);
    cyc("ld6_fwd", 2, 0, 0, 0);

    // freeze with ALU x4 in MEM, then asynchronous reset mid-freeze
    drv(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); cyc("alu4_in", -1, -1, 0, -1);
    drv(1, 4, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc("frz4", 1, 0, 0, 1);
    reset_pulse("rst_mid");
    cyc("post_rst", 0, 0, 0, 0);
    drv(1, 4, 1, 4, 1, 0, 0, 0, 0, 0); cyc("post_rst2", 0, 0, 0, 0);

    // random traffic over a small register window so dependencies are frequent
    for (int n = 0; n < 400; n++) begin
      drv(($urandom_range(0, 9) != 0), $urandom_range(0, 7), 1'($urandom),
          $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
          1'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
      cyc("rand", -1, -1, -1, -1);
      if ($urandom_range(0, 149) == 0) reset_pulse("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
